// File: rtl/pred_check_pkg.sv
// Shared types for the PC prediction checker: FSM states, PC and counter widths.
package pred_check_pkg;

  localparam int unsigned PC_W  = 64;
  localparam int unsigned CNT_W = 32;

  typedef logic [PC_W-1:0]  pc_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/pred_check_fifo.sv
// Prediction FIFO: DEPTH x 64, first-word-fall-through head, synchronous flush.
module pred_fifo
  import pred_check_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  pc_t  din,
  output pc_t  dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  pc_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is accepted only when a pop frees a slot the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pred_check.sv
// Compares predicted PCs from iu against committed PCs; raises miss until iu re-syncs.
module pred_check
  import pred_check_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] pc_pre,
  input  logic        pc_pre_oe,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  output logic        miss,
  output logic [63:0] pc_curr,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] skip_cnt,
  output logic        overflow
);

  state_t state;
  state_t state_nx;

  pc_t  fifo_head;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_flush;

  logic in_run;
  logic hit;
  logic mism;
  logic skip;
  logic ovf_set;

  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (pc_pre),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    in_run     = (state == RUN);
    fifo_push  = in_run && pc_pre_oe;
    fifo_pop   = in_run && commit_valid && !fifo_empty;
    hit        = fifo_pop && (fifo_head == commit_pc);
    mism       = fifo_pop && (fifo_head != commit_pc);
    skip       = commit_valid && !fifo_pop;
    // Flushing outside RUN keeps the FIFO empty regardless of what iu sends.
    fifo_flush = mism || !in_run;
    ovf_set    = fifo_push && fifo_full && !fifo_pop;
    state_nx   = state;
    case (state)
      RUN:     if (mism)      state_nx = FLUSH;
      FLUSH:   if (pc_pre_oe) state_nx = ACK;
      ACK:                    state_nx = RUN;
      default:                state_nx = RUN;
    endcase
  end

  assign miss = (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_curr  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      skip_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (commit_valid) begin
        pc_curr <= commit_pc;
      end
      if (hit) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
      if (mism) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
      if (skip) begin
        skip_cnt <= skip_cnt + 1'b1;
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
